capture_uart_streamer: RTL and testbench

Drains captured sample records from the channel FIFO and streams them out over a UART 8N1 transmit line, one framed record at a time. Sits directly downstream of the capture FIFO (written by the pin-change / time-stepper path); it owns the FIFO read side (`rdreq`, `q`, `empty`). Each 32-bit record is sent as a sync byte followed by four payload bytes, so a host can resynchronise mid-stream.

---
 rtl/capture_uart_streamer_pkg.sv | 28 ++
 rtl/capture_uart_streamer_uart_tx_byte.sv | 83 ++++++++
 rtl/capture_uart_streamer.sv | 114 +++++++++++
 tb/tb_capture_uart_streamer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/capture_uart_streamer_pkg.sv
// capture_uart_streamer_pkg
// Shared constants, FSM state type and byte-selection helper for the
// capture FIFO -> UART record streamer.
package capture_uart_streamer_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         RECORD_BYTES      = 5;   // sync + 4 payload bytes
    localparam int         UART_FRAME_BITS   = 10;  // start + 8 data + stop

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SEND
    } state_e;

    // Payload byte idx (1..4) of a record, most significant byte first.
    function automatic logic [7:0] payload_byte(input logic [31:0] rec,
                                                input logic [2:0]  idx);
        case (idx)
            3'd1:    return rec[31:24];
            3'd2:    return rec[23:16];
            3'd3:    return rec[15:8];
            default: return rec[7:0];
        endcase
    endfunction

endpackage

// File: rtl/capture_uart_streamer_uart_tx_byte.sv
// uart_tx_byte
// Sends one 8N1 byte: start bit (0), 8 data bits LSB first, stop bit (1),
// each held CLKS_PER_BIT cycles.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_start       load i_byte and begin a frame (taken when idle or in the
//                 last stop-bit cycle, so bytes can be chained gap-free)
//   i_byte        byte to send
//   o_tx          registered TX line, idle high
//   o_done        high during the last cycle of the stop bit
module uart_tx_byte
    import capture_uart_streamer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_done
);

    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     BIT_STOP  = 4'(UART_FRAME_BITS - 1);

    logic          active_q, active_d;
    logic [CW-1:0] baud_q,   baud_d;
    logic [3:0]    bit_q,    bit_d;
    logic [7:0]    data_q,   data_d;
    logic          tx_q,     tx_d;
    logic          last_cycle;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            active_q <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            tx_q     <= tx_d;
        end
    end

    always_comb begin
        last_cycle = active_q && (baud_q == BAUD_LAST) && (bit_q == BIT_STOP);
        active_d   = active_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        data_d     = data_q;
        tx_d       = tx_q;
        if (i_start && (!active_q || last_cycle)) begin
            active_d = 1'b1;
            baud_d   = '0;
            bit_d    = '0;
            data_d   = i_byte;
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_d = '0;
                if (bit_q == BIT_STOP) begin
                    active_d = 1'b0;            // line is already high
                end else begin
                    bit_d = bit_q + 4'd1;
                    // bit_q 0..7 moves onto data bit bit_q; bit_q 8 onto stop
                    tx_d  = (bit_q == BIT_STOP - 4'd1) ? 1'b1 : data_q[bit_q[2:0]];
                end
            end else begin
                baud_d = baud_q + 1'b1;
            end
        end
    end

    assign o_tx   = tx_q;
    assign o_done = last_cycle;

endmodule

// File: rtl/capture_uart_streamer.sv
// capture_uart_streamer
// Pops 32-bit capture records from the FIFO and sends each as a UART frame
// sequence: SYNC_BYTE, q[31:24], q[23:16], q[15:8], q[7:0].
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_enable          streaming allowed; only looked at when a record starts
//   i_fifo_empty      FIFO empty flag
//   i_fifo_q          FIFO data, valid the cycle after o_fifo_rdreq
//   o_fifo_rdreq      one-cycle pop strobe
//   o_tx              UART TX line (idle high)
//   o_busy            record being fetched or sent
//   o_words_sent      completed-record count, wraps
module capture_uart_streamer
    import capture_uart_streamer_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_fifo_empty,
    input  logic [31:0] i_fifo_q,
    output logic        o_fifo_rdreq,
    output logic        o_tx,
    output logic        o_busy,
    output logic [15:0] o_words_sent
);

    localparam logic [2:0] LAST_BYTE = 3'(RECORD_BYTES - 1);

    state_e      state_q,    state_d;
    logic [31:0] record_q,   record_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [15:0] words_q,    words_d;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_done;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(tx_start),
        .i_byte (tx_byte),
        .o_tx   (o_tx),
        .o_done (tx_done)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            record_q   <= '0;
            byte_idx_q <= '0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            record_q   <= record_d;
            byte_idx_q <= byte_idx_d;
            words_q    <= words_d;
        end
    end

    // Next state and byte sequencing
    always_comb begin
        state_d    = state_q;
        record_d   = record_q;
        byte_idx_d = byte_idx_q;
        words_d    = words_q;
        tx_start   = 1'b0;
        tx_byte    = SYNC_BYTE;
        case (state_q)
            ST_IDLE: begin
                if (i_enable && !i_fifo_empty) state_d = ST_REQ;
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Sync byte needs no FIFO data, so it starts while q is latched.
                record_d   = i_fifo_q;
                byte_idx_d = '0;
                tx_start   = 1'b1;
                tx_byte    = SYNC_BYTE;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (tx_done) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        words_d = words_q + 16'd1;
                        state_d = (i_enable && !i_fifo_empty) ? ST_REQ : ST_IDLE;
                    end else begin
                        // Chain the next byte into the stop bit's last cycle.
                        tx_start   = 1'b1;
                        tx_byte    = payload_byte(record_q, byte_idx_q + 3'd1);
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        o_fifo_rdreq = (state_q == ST_REQ);
        o_busy       = (state_q != ST_IDLE);
    end

    assign o_words_sent = words_q;

endmodule

// File: tb/tb_capture_uart_streamer.sv
module tb_capture_uart_streamer;

    localparam int         CPB  = 4;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         FRAME = 10 * CPB;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_fifo_empty;
    logic [31:0] i_fifo_q = '0;
    logic        o_fifo_rdreq;
    logic        o_tx;
    logic        o_busy;
    logic [15:0] o_words_sent;

    always #5 i_clk = ~i_clk;

    capture_uart_streamer #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (SYNC)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_enable    (i_enable),
        .i_fifo_empty(i_fifo_empty),
        .i_fifo_q    (i_fifo_q),
        .o_fifo_rdreq(o_fifo_rdreq),
        .o_tx        (o_tx),
        .o_busy      (o_busy),
        .o_words_sent(o_words_sent)
    );

    // FIFO model: registered read data, pointers into a small ring.
    logic [31:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign i_fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge i_clk) begin
        if (o_fifo_rdreq && (rd_ptr != wr_ptr)) begin
            i_fifo_q <= mem[rd_ptr % 16];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Line trace and handshake statistics from the last capture
    logic tx_tr [0:1023];
    int   n_cap, rd_cnt, rd_first, rd_empty_cnt, zero_cnt;
    // Decoded bytes
    logic [7:0] dec [0:15];
    logic       stop_ok [0:15];
    int         st [0:15];
    int         ndec;

    function automatic logic [7:0] frame_byte(input logic [31:0] w, input int k);
        if (k == 0) return SYNC;
        return w[8*(4-k) +: 8];
    endfunction

    task automatic push_word(input logic [31:0] w);
        mem[wr_ptr % 16] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic apply_reset();
        i_enable = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        wr_ptr = rd_ptr;
    endtask

    task automatic capture(input int ncyc, input int drop_at);
        rd_cnt = 0; rd_first = -1; rd_empty_cnt = 0; zero_cnt = 0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge i_clk);
            tx_tr[n] = o_tx;
            if (o_fifo_rdreq) begin
                if (rd_cnt == 0) rd_first = n;
                rd_cnt++;
                if (i_fifo_empty) rd_empty_cnt++;
            end
            if (o_tx !== 1'b1) zero_cnt++;
            if (n == drop_at) i_enable = 1'b0;
        end
        n_cap = ncyc;
    endtask

    // Plain UART receiver over the captured trace, sampling mid-bit.
    task automatic decode(input int from, input int nb);
        int i;
        ndec = 0;
        i = from;
        for (int b = 0; b < nb; b++) begin
            while (i < n_cap && tx_tr[i] !== 1'b0) i++;
            if (i + FRAME > n_cap) break;
            st[b] = i;
            for (int j = 0; j < 8; j++) dec[b][j] = tx_tr[i + CPB*(j+1) + CPB/2];
            stop_ok[b] = tx_tr[i + CPB*9 + CPB/2];
            ndec++;
            i = i + FRAME;
        end
    endtask

    task automatic check_bytes(input string tag, input logic [31:0] w0,
                               input logic [31:0] w1, input logic [31:0] w2,
                               input int nwords);
        logic [31:0] wl [0:2];
        logic [7:0]  exp_b;
        wl[0] = w0; wl[1] = w1; wl[2] = w2;
        n_cmp++;
        if (ndec !== 5*nwords) begin
            n_bad++;
            $display("FAIL %s byte_count: got %0d want %0d", tag, ndec, 5*nwords);
        end
        for (int b = 0; b < 5*nwords && b < ndec; b++) begin
            exp_b = frame_byte(wl[b/5], b%5);
            n_cmp++;
            if (dec[b] !== exp_b || stop_ok[b] !== 1'b1) begin
                n_bad++;
                $display("FAIL %s byte%0d: got %h stop %b want %h stop 1",
                         tag, b, dec[b], stop_ok[b], exp_b);
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        n_cmp += 4;
        if (o_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", o_tx); end
        if (o_fifo_rdreq !== 1'b0) begin n_bad++; $display("FAIL reset_rdreq: got %b want 0", o_fifo_rdreq); end
        if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        if (o_words_sent !== 16'd0) begin n_bad++; $display("FAIL reset_words: got %h want 0", o_words_sent); end
        i_rst = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        push_word(32'h1234_5678);
        i_enable = 1'b1;
        capture(260, -1);
        decode(0, 5);
        check_bytes("single", 32'h1234_5678, 32'h0, 32'h0, 1);
        n_cmp += 6;
        if (rd_cnt !== 1) begin n_bad++; $display("FAIL single_pops: got %0d want 1", rd_cnt); end
        if (rd_empty_cnt !== 0) begin n_bad++; $display("FAIL single_pop_empty: got %0d want 0", rd_empty_cnt); end
        if (ndec > 0 && st[0] - rd_first !== 2) begin n_bad++; $display("FAIL single_latency: got %0d want 2", st[0] - rd_first); end
        if (ndec == 5 && (st[4] + FRAME - st[0]) !== 200) begin n_bad++; $display("FAIL single_frame_len: got %0d want 200", st[4] + FRAME - st[0]); end
        if (o_words_sent !== 16'd1) begin n_bad++; $display("FAIL single_words: got %0d want 1", o_words_sent); end
        if (o_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [0:2];
        apply_reset();
        for (int k = 0; k < 3; k++) begin w[k] = $urandom; push_word(w[k]); end
        i_enable = 1'b1;
        capture(650, -1);
        decode(0, 15);
        check_bytes("b2b", w[0], w[1], w[2], 3);
        n_cmp += 3;
        if (rd_cnt !== 3) begin n_bad++; $display("FAIL b2b_pops: got %0d want 3", rd_cnt); end
        if (rd_empty_cnt !== 0) begin n_bad++; $display("FAIL b2b_pop_empty: got %0d want 0", rd_empty_cnt); end
        if (o_words_sent !== 16'd3) begin n_bad++; $display("FAIL b2b_words: got %0d want 3", o_words_sent); end
        for (int r = 1; r < 3; r++) begin
            if (ndec >= 5*r + 1) begin
                n_cmp++;
                if (st[5*r] - (st[5*r-1] + FRAME) !== 2) begin
                    n_bad++;
                    $display("FAIL b2b_gap%0d: got %0d want 2", r, st[5*r] - (st[5*r-1] + FRAME));
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [31:0] w0, w1;
        apply_reset();
        w0 = $urandom; w1 = $urandom;
        push_word(w0); push_word(w1);
        i_enable = 1'b1;
        capture(300, 90);   // byte 2 occupies trace samples 82..121
        decode(0, 5);
        check_bytes("drop", w0, 32'h0, 32'h0, 1);
        n_cmp += 4;
        if (rd_cnt !== 1) begin n_bad++; $display("FAIL drop_pops: got %0d want 1", rd_cnt); end
        if (o_words_sent !== 16'd1) begin n_bad++; $display("FAIL drop_words: got %0d want 1", o_words_sent); end
        if (o_busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy: got %b want 0", o_busy); end
        if (wr_ptr - rd_ptr !== 1) begin n_bad++; $display("FAIL drop_fifo_left: got %0d want 1", wr_ptr - rd_ptr); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w0, w1;
        apply_reset();
        w0 = $urandom; w1 = $urandom;
        push_word(w0); push_word(w1);
        i_enable = 1'b1;
        capture(124, -1);   // byte 3 start bit occupies samples 122..125
        n_cmp++;
        if (tx_tr[123] !== 1'b0) begin n_bad++; $display("FAIL mid_start_bit: got %b want 0", tx_tr[123]); end
        i_rst = 1'b1;
        #1;
        n_cmp += 3;
        if (o_tx !== 1'b1) begin n_bad++; $display("FAIL mid_rst_tx: got %b want 1", o_tx); end
        if (o_busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b want 0", o_busy); end
        if (o_words_sent !== 16'd0) begin n_bad++; $display("FAIL mid_rst_words: got %0d want 0", o_words_sent); end
        @(negedge i_clk);
        i_rst = 1'b0;
        capture(260, -1);
        decode(0, 5);
        check_bytes("mid_after", w1, 32'h0, 32'h0, 1);
        n_cmp += 2;
        if (rd_cnt !== 1) begin n_bad++; $display("FAIL mid_after_pops: got %0d want 1", rd_cnt); end
        if (o_words_sent !== 16'd1) begin n_bad++; $display("FAIL mid_after_words: got %0d want 1", o_words_sent); end
    endtask

    task automatic test_empty();
        apply_reset();
        i_enable = 1'b1;
        capture(1000, -1);
        n_cmp += 3;
        if (rd_cnt !== 0) begin n_bad++; $display("FAIL empty_pops: got %0d want 0", rd_cnt); end
        if (zero_cnt !== 0) begin n_bad++; $display("FAIL empty_tx_low: got %0d want 0", zero_cnt); end
        if (o_busy !== 1'b0) begin n_bad++; $display("FAIL empty_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_wrap();
        logic [31:0] w0;
        apply_reset();
        force dut.words_q = 16'hFFFF;
        @(negedge i_clk);
        release dut.words_q;
        w0 = $urandom;
        push_word(w0);
        i_enable = 1'b1;
        capture(230, -1);
        decode(0, 5);
        check_bytes("wrap", w0, 32'h0, 32'h0, 1);
        n_cmp++;
        if (o_words_sent !== 16'd0) begin n_bad++; $display("FAIL wrap_words: got %h want 0000", o_words_sent); end
    endtask

    task automatic test_random_batches();
        logic [31:0] w [0:2];
        int nw;
        for (int it = 0; it < 2; it++) begin
            apply_reset();
            nw = $urandom_range(1, 3);
            w[0] = 0; w[1] = 0; w[2] = 0;
            for (int k = 0; k < nw; k++) begin w[k] = $urandom; push_word(w[k]); end
            i_enable = 1'b1;
            capture(650, -1);
            decode(0, 5*nw);
            check_bytes("rand", w[0], w[1], w[2], nw);
            n_cmp += 2;
            if (rd_cnt !== nw) begin n_bad++; $display("FAIL rand_pops: got %0d want %0d", rd_cnt, nw); end
            if (o_words_sent !== 16'(nw)) begin n_bad++; $display("FAIL rand_words: got %0d want %0d", o_words_sent, nw); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_empty();
        test_wrap();
        test_random_batches();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
